// File: rtl/anim_pkg.sv
// Shared types and defaults for the animation playback controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package anim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2
  } anim_state_t;

  localparam int NUM_CLIPS_DEF = 4;
  localparam int PIX_W_DEF     = 16;
  localparam int FRAME_W_DEF   = 4;
  localparam int TICK_W_DEF    = 24;

  // Pixel shown while nothing is playing
  localparam logic [15:0] BLANK_PIX = 16'h0000;

endpackage

// File: rtl/frame_timer.sv
// Frame-period timer: latches max(period,1) on load and pulses frame_tick every period_r running cycles.
// Latency: first frame_tick is combinational in the cycle period_r-1 cycles after the load edge.
// Backpressure: none; the counter only advances while run is high and freezes otherwise.
module frame_timer #(
  parameter int TICK_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TICK_W-1:0] period,
  input  logic              run,
  output logic              frame_tick
);

  logic [TICK_W-1:0] period_r;
  logic [TICK_W-1:0] cnt_r;

  assign frame_tick = run && (cnt_r == period_r - TICK_W'(1));

  // Period latch and 0..period_r-1 counter; a zero period behaves as one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_r <= TICK_W'(1);
      cnt_r    <= '0;
    end else if (load) begin
      period_r <= (period == '0) ? TICK_W'(1) : period;
      cnt_r    <= '0;
    end else if (run) begin
      cnt_r    <= frame_tick ? '0 : cnt_r + TICK_W'(1);
    end
  end

endmodule

// File: rtl/anim_ctrl.sv
// Animation playback controller: accepts clip requests, steps frame_idx at a programmable rate, muxes pixel data.
// Latency: clip_sel/frame_idx update on the accept edge; ram_data is one register after clip_data/clip_sel.
// Backpressure: req_ready drops while a one-shot clip plays or stop is high. Option: ANIM_CTRL_PINGPONG_EN (bouncing loops).
module anim_ctrl
  import anim_pkg::*;
#(
  parameter  int NUM_CLIPS = NUM_CLIPS_DEF,
  parameter  int FRAME_W   = FRAME_W_DEF,
  parameter  int TICK_W    = TICK_W_DEF,
  parameter  int PIX_W     = PIX_W_DEF,
  localparam int CLIP_W    = $clog2(NUM_CLIPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TICK_W-1:0]      tick_period,
  input  logic                   req_valid,
  input  logic [CLIP_W-1:0]      req_clip,
  input  logic                   req_loop,
  output logic                   req_ready,
  input  logic                   stop,
  input  logic [NUM_CLIPS*PIX_W-1:0] clip_data,
  output logic [CLIP_W-1:0]      clip_sel,
  output logic [FRAME_W-1:0]     frame_idx,
  output logic [PIX_W-1:0]       ram_data,
  output logic                   busy,
  output logic                   done
);

  anim_state_t        state_r;
  anim_state_t        state_nxt;
  logic               loop_r;
  logic               accept;
  logic               frame_tick;
  logic               advance;
  logic               at_max;
  logic               hold_entry;
  logic [FRAME_W-1:0] idx_adv;

  assign accept     = req_valid && req_ready;
  assign advance    = (state_r == ST_PLAY) && frame_tick;
  assign at_max     = (frame_idx == {FRAME_W{1'b1}});
  assign hold_entry = (state_r == ST_PLAY) && (state_nxt == ST_HOLD);

  frame_timer #(.TICK_W(TICK_W)) u_frame_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .period     (tick_period),
    .run        (state_r == ST_PLAY),
    .frame_tick (frame_tick)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt;
  end

  // Next state: stop beats a request, a request beats the frame advance
  always_comb begin
    state_nxt = state_r;
    if (stop)
      state_nxt = ST_IDLE;
    else if (accept)
      state_nxt = ST_PLAY;
    else if (advance && at_max && !loop_r)
      state_nxt = ST_HOLD;
  end

  // Outputs decoded from state; only a playing one-shot refuses requests
  always_comb begin
    busy      = 1'b0;
    req_ready = !stop;
    if (state_r == ST_PLAY) begin
      busy      = 1'b1;
      req_ready = !stop && loop_r;
    end
  end

`ifdef ANIM_CTRL_PINGPONG_EN
  logic dir_down;
  logic at_zero;

  assign at_zero = (frame_idx == '0);

  // Bounce direction for looping clips; every accept restarts upward
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dir_down <= 1'b0;
    else if (!stop && accept)
      dir_down <= 1'b0;
    else if (!stop && advance && loop_r) begin
      if (!dir_down && at_max)
        dir_down <= 1'b1;
      else if (dir_down && at_zero)
        dir_down <= 1'b0;
    end
  end

  // Next frame on a tick: bounce at either end when looping, park at max for one-shot
  always_comb begin
    idx_adv = frame_idx + FRAME_W'(1);
    if (!loop_r) begin
      if (at_max) idx_adv = frame_idx;
    end else if (dir_down) begin
      idx_adv = at_zero ? FRAME_W'(1) : frame_idx - FRAME_W'(1);
    end else if (at_max) begin
      idx_adv = frame_idx - FRAME_W'(1);
    end
  end
`else
  // Next frame on a tick: wrap to 0 when looping, park at max for one-shot
  always_comb begin
    idx_adv = frame_idx + FRAME_W'(1);
    if (at_max)
      idx_adv = loop_r ? '0 : frame_idx;
  end
`endif

  // Clip/frame registers; stop keeps the clip but rewinds the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_sel  <= '0;
      frame_idx <= '0;
      loop_r    <= 1'b0;
    end else if (stop) begin
      frame_idx <= '0;
    end else if (accept) begin
      clip_sel  <= req_clip;
      loop_r    <= req_loop;
      frame_idx <= '0;
    end else if (advance) begin
      frame_idx <= idx_adv;
    end
  end

  // done pulses for the single cycle after a one-shot parks in HOLD
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= hold_entry;
  end

  // Registered pixel mux; blank while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ram_data <= PIX_W'(BLANK_PIX);
    else if (state_r == ST_IDLE)
      ram_data <= PIX_W'(BLANK_PIX);
    else
      ram_data <= clip_data[clip_sel*PIX_W +: PIX_W];
  end

endmodule

// File: tb/tb_anim_ctrl.sv
// Scoreboard bench for anim_ctrl: directed requests push expected output events, a monitor pops them on change.
// Latency: events carry the expected edge distance from the previous event.
// Backpressure: exercised through one-shot refusal, preemption and stop dominance.
module tb_anim_ctrl;

`ifdef ANIM_CTRL_PINGPONG_EN
  localparam int FW = 2;
`else
  localparam int FW = 4;
`endif
  localparam int MAXF = (1 << FW) - 1;

  typedef struct {
    logic          busy;
    logic          done;
    logic [1:0]    clip;
    logic [FW-1:0] idx;
    int            gap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [23:0]   tick_period;
  logic          req_valid;
  logic [1:0]    req_clip;
  logic          req_loop;
  logic          req_ready;
  logic          stop;
  logic [63:0]   clip_data;
  logic [1:0]    clip_sel;
  logic [FW-1:0] frame_idx;
  logic [15:0]   ram_data;
  logic          busy;
  logic          done;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   last_cyc = 0;
  logic          p_busy = 1'b0;
  logic          p_done = 1'b0;
  logic [1:0]    p_clip = '0;
  logic [FW-1:0] p_idx  = '0;

  anim_ctrl #(.NUM_CLIPS(4), .FRAME_W(FW), .TICK_W(24), .PIX_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_period (tick_period),
    .req_valid   (req_valid),
    .req_clip    (req_clip),
    .req_loop    (req_loop),
    .req_ready   (req_ready),
    .stop        (stop),
    .clip_data   (clip_data),
    .clip_sel    (clip_sel),
    .frame_idx   (frame_idx),
    .ram_data    (ram_data),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // k-th frame index of a looping clip started at frame 0
  function automatic int loop_seq(input int k);
`ifdef ANIM_CTRL_PINGPONG_EN
    int m;
    m = k % (2 * MAXF);
    return (m <= MAXF) ? m : 2 * MAXF - m;
`else
    return k % (MAXF + 1);
`endif
  endfunction

  task automatic push(input logic b, input logic d, input logic [1:0] c, input int i, input int g);
    exp_t e;
    e.busy = b; e.done = d; e.clip = c; e.idx = FW'(i); e.gap = g;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Monitor: any change of {busy,done,clip_sel,frame_idx} is an output event
  always @(negedge clk) begin
    exp_t e;
    if ({busy, done, clip_sel, frame_idx} !== {p_busy, p_done, p_clip, p_idx}) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: busy=%0b done=%0b clip=%0d idx=%0d at cycle %0d",
                 busy, done, clip_sel, frame_idx, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({busy, done, clip_sel, frame_idx} !== {e.busy, e.done, e.clip, e.idx}) begin
          n_bad++;
          $display("FAIL event: got busy=%0b done=%0b clip=%0d idx=%0d, want busy=%0b done=%0b clip=%0d idx=%0d",
                   busy, done, clip_sel, frame_idx, e.busy, e.done, e.clip, e.idx);
        end
        if (e.gap >= 0) begin
          n_cmp++;
          if (cyc - last_cyc != e.gap) begin
            n_bad++;
            $display("FAIL event_gap: got %0d cycles, want %0d (idx=%0d)", cyc - last_cyc, e.gap, frame_idx);
          end
        end
      end
      p_busy = busy; p_done = done; p_clip = clip_sel; p_idx = frame_idx;
      last_cyc = cyc;
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_%s: %0d events pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // One-cycle drive; the second posedge is the effective edge
  task automatic pulse(input logic v, input logic [1:0] c, input logic l, input logic [23:0] p, input logic s);
    @(posedge clk); #1;
    req_valid = v; req_clip = c; req_loop = l; tick_period = p; stop = s;
    @(posedge clk); #1;
    req_valid = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_period = '0; req_valid = 1'b0; req_clip = '0; req_loop = 1'b0; stop = 1'b0;
    clip_data = {16'h001F, 16'h07E0, 16'hF800, 16'h1234};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_clip_sel", 32'(clip_sel), 0);
    chk("rst_frame_idx", 32'(frame_idx), 0);
    chk("rst_ram_data", 32'(ram_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("rst_req_ready", 32'(req_ready), 1);

    // Loop clip 2, period 4
    push(1, 0, 2, 0, -1);
    for (int k = 1; k <= MAXF + 1; k++) push(1, 0, 2, loop_seq(k), 4);
    pulse(1, 2, 1, 24'd4, 0);
    chk("loop_ram_data_lat0", 32'(ram_data), 0);
    @(posedge clk); #1 chk("loop_ram_data", 32'(ram_data), 32'h07E0);
    chk("loop_ready", 32'(req_ready), 1);
    wait_drain("loop", 400);

    // stop together with a request: stop wins, request dropped
    push(0, 0, 2, 0, 2);
    @(posedge clk); #1;
    req_valid = 1'b1; req_clip = 2'd1; req_loop = 1'b0; tick_period = 24'd5; stop = 1'b1;
    #1 chk("stop_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    req_valid = 1'b0; stop = 1'b0;
    chk("stop_clip_sel", 32'(clip_sel), 2);
    chk("stop_ram_prev", 32'(ram_data), 32'h07E0);
    @(posedge clk); #1 chk("stop_ram_blank", 32'(ram_data), 0);
    wait_drain("stop", 20);

    // One-shot clip 1, period 1
    push(1, 0, 1, 0, -1);
    for (int k = 1; k <= MAXF; k++) push(1, 0, 1, k, 1);
    push(0, 1, 1, MAXF, 1);
    push(0, 0, 1, MAXF, 1);
    pulse(1, 1, 0, 24'd1, 0);
    chk("oneshot_ready_play", 32'(req_ready), 0);
    @(posedge clk); #1 chk("oneshot_ram_data", 32'(ram_data), 32'hF800);
    req_valid = 1'b1; req_clip = 2'd3; req_loop = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    wait_drain("oneshot", 100);
    chk("hold_ready", 32'(req_ready), 1);
    chk("hold_ram_data", 32'(ram_data), 32'hF800);

    // Loop clip 0 period 3, preempted by clip 3 on its frame_tick cycle
    push(1, 0, 0, 0, -1);
    push(1, 0, 0, 1, 3);
    push(1, 0, 3, 0, 3);
    push(1, 0, 3, 1, 2);
    pulse(1, 0, 1, 24'd3, 0);
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    req_valid = 1'b1; req_clip = 2'd3; req_loop = 1'b1; tick_period = 24'd2;
    #1 chk("preempt_ready", 32'(req_ready), 1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_drain("preempt", 50);
    push(0, 0, 3, 0, 2);
    pulse(0, 0, 0, 24'd0, 1);
    wait_drain("preempt_stop", 20);

    // tick_period 0 behaves as period 1 (loop clip 1)
    push(1, 0, 1, 0, -1);
    for (int k = 1; k <= MAXF + 1; k++) push(1, 0, 1, loop_seq(k), 1);
    pulse(1, 1, 1, 24'd0, 0);
    @(posedge clk); #1 chk("zero_period_ram_data", 32'(ram_data), 32'hF800);
    wait_drain("zero_period", 100);
    push(1, 0, 1, loop_seq(MAXF + 2), 1);
    push(0, 0, 1, 0, 1);
    pulse(0, 0, 0, 24'd0, 1);
    wait_drain("zero_period_stop", 20);

    // Loop clip 3 period 1, async reset mid-sequence
    for (int k = 0; k < 8; k++) push(1, 0, 3, loop_seq(k), (k == 0) ? -1 : 1);
    push(0, 0, 0, 0, -1);
    pulse(1, 3, 1, 24'd1, 0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_clip_sel", 32'(clip_sel), 0);
    chk("arst_frame_idx", 32'(frame_idx), 0);
    chk("arst_ram_data", 32'(ram_data), 0);
    chk("arst_req_ready", 32'(req_ready), 1);
    @(posedge clk); #1 rst = 1'b0;
    wait_drain("arst", 10);
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
